// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// FSM state encoding (one-hot owners, matches the grant output) and bus widths.
package wb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        OWN0 = ST_OWN0,
        OWN1 = ST_OWN1
    } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-cycle watchdog: counts unacknowledged strobe cycles of the current owner,
// pulses expire at TIMEOUT_CYCLES-1 and keeps a sticky timeout flag until reset.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic owning,
    input  logic stb,
    input  logic ack,
    output logic expire,
    output logic timeout_flag
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_r;
    logic             flag_r;

    // Expiry pulse: owner has been strobing without an ack for the full budget
    always_comb begin
        expire = owning && stb && !ack && (count_r >= LIMIT);
    end

    // Counter (saturating, restarts after a forced termination) and sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            flag_r  <= 1'b0;
        end else begin
            if (!owning || !stb || ack || expire) begin
                count_r <= '0;
            end else if (count_r != CNT_MAX) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            if (expire) begin
                flag_r <= 1'b1;
            end else begin
                flag_r <= flag_r;
            end
        end
    end

    assign timeout_flag = flag_r;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone classic round-robin arbiter with combinational slave mux.
// Optional slave watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 255,
    parameter logic [DAT_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_w,
    input  logic [SEL_W-1:0] m0_sel,
    output logic             m0_ack,
    output logic [DAT_W-1:0] m0_dat_r,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_w,
    input  logic [SEL_W-1:0] m1_sel,
    output logic             m1_ack,
    output logic [DAT_W-1:0] m1_dat_r,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_w,
    output logic [SEL_W-1:0] s_sel,
    input  logic             s_ack,
    input  logic [DAT_W-1:0] s_dat_r,
    output logic [1:0]       grant,
    output logic             timeout_flag
);

    arb_state_t state_r, next_state_s;
    logic       last_owner_r;
    logic       expire_s;

`ifdef WB_ARB_TIMEOUT_EN
    logic owning_s;
    logic own_stb_s;

    assign owning_s  = (state_r != IDLE);
    assign own_stb_s = (state_r == OWN0) ? m0_stb :
                       (state_r == OWN1) ? m1_stb : 1'b0;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .owning       (owning_s),
        .stb          (own_stb_s),
        .ack          (s_ack),
        .expire       (expire_s),
        .timeout_flag (timeout_flag)
    );
`else
    assign expire_s     = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // State register and round-robin history (last_owner starts at 1 so master 0 wins first)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if (state_r == OWN0 && !m0_cyc) begin
                last_owner_r <= 1'b0;
            end else if (state_r == OWN1 && !m1_cyc) begin
                last_owner_r <= 1'b1;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Next-state: whole-cycle tenure, release on cyc fall, contention goes to the other master
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    next_state_s = last_owner_r ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    next_state_s = OWN0;
                end else if (m1_cyc) begin
                    next_state_s = OWN1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN0: next_state_s = m0_cyc ? OWN0 : IDLE;
            OWN1: next_state_s = m1_cyc ? OWN1 : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Bus mux; a watchdog expiry cuts the slave strobe and acks the owner with ERR_DATA
    always_comb begin
        grant    = state_r;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_w  = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_dat_r = '0;
        case (state_r)
            OWN0: begin
                s_cyc    = m0_cyc & ~expire_s;
                s_stb    = m0_stb & ~expire_s;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_w  = m0_dat_w;
                s_sel    = m0_sel;
                m0_ack   = s_ack | expire_s;
                m0_dat_r = expire_s ? ERR_DATA : s_dat_r;
            end
            OWN1: begin
                s_cyc    = m1_cyc & ~expire_s;
                s_stb    = m1_stb & ~expire_s;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_w  = m1_dat_w;
                s_sel    = m1_sel;
                m1_ack   = s_ack | expire_s;
                m1_dat_r = expire_s ? ERR_DATA : s_dat_r;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Table-driven bench for wb_rr_arbiter: one record per clock cycle of inputs and
// expected outputs, plus hand-built sequences for the watchdog / hung-slave case.
module tb_wb_rr_arbiter;

    localparam int          TO   = 8;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam logic [31:0] A0   = 32'h0300_0000;
    localparam logic [31:0] A1   = 32'h0300_0010;
    localparam logic [31:0] W0   = 32'h0000_00A5;
    localparam logic [31:0] W1   = 32'h5555_AAAA;
    localparam logic [3:0]  SEL0 = 4'hF;
    localparam logic [3:0]  SEL1 = 4'h3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_dat_r, m1_dat_r;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w;
    logic [3:0]  s_sel;
    logic        s_ack = 1'b0;
    logic [31:0] s_dat_r = 32'h0;
    logic [1:0]  grant;
    logic        timeout_flag;

    int n_vec = 0;
    int n_bad = 0;

    assign m0_adr = A0;  assign m0_dat_w = W0;  assign m0_sel = SEL0;
    assign m1_adr = A1;  assign m1_dat_w = W1;  assign m1_sel = SEL1;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_dat_r(s_dat_r),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    typedef struct {
        string       name;
        logic        r, c0, s0, w0, c1, s1, w1, ak;
        logic [31:0] dr;
        logic [1:0]  g;
        logic        sc, ss, sw, a0, a1;
        logic [31:0] d0, d1;
        logic        tf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic r,
                                input logic c0, input logic s0, input logic w0,
                                input logic c1, input logic s1, input logic w1,
                                input logic ak, input logic [31:0] dr,
                                input logic [1:0] g, input logic sc, input logic ss, input logic sw,
                                input logic a0, input logic a1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic tf);
        vec_t v;
        v.name = nm; v.r = r; v.c0 = c0; v.s0 = s0; v.w0 = w0;
        v.c1 = c1; v.s1 = s1; v.w1 = w1; v.ak = ak; v.dr = dr;
        v.g = g; v.sc = sc; v.ss = ss; v.sw = sw; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.tf = tf;
        return v;
    endfunction

    // Drive one cycle of inputs after the rising edge, check outputs on the falling edge.
    // Slave-side address/data/sel expectations follow the expected owner.
    task automatic apply(input vec_t v);
        logic [31:0] ea, ew;
        logic [3:0]  es;
        @(posedge clk); #1;
        reset = v.r;
        m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.w0;
        m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.w1;
        s_ack = v.ak;  s_dat_r = v.dr;
        @(negedge clk);
        ea = (v.g == 2'b01) ? A0   : (v.g == 2'b10) ? A1   : 32'h0;
        ew = (v.g == 2'b01) ? W0   : (v.g == 2'b10) ? W1   : 32'h0;
        es = (v.g == 2'b01) ? SEL0 : (v.g == 2'b10) ? SEL1 : 4'h0;
        n_vec++;
        if ({grant, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, m0_ack, m1_ack, m0_dat_r, m1_dat_r, timeout_flag}
            !== {v.g, v.sc, v.ss, v.sw, ea, ew, es, v.a0, v.a1, v.d0, v.d1, v.tf}) begin
            n_bad++;
            $display("FAIL %s: got grant=%b cyc/stb/we=%b%b%b adr=%h dw=%h sel=%h ack=%b%b d0=%h d1=%h tf=%b; want grant=%b cyc/stb/we=%b%b%b adr=%h dw=%h sel=%h ack=%b%b d0=%h d1=%h tf=%b",
                     v.name, grant, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, m0_ack, m1_ack, m0_dat_r, m1_dat_r, timeout_flag,
                     v.g, v.sc, v.ss, v.sw, ea, ew, es, v.a0, v.a1, v.d0, v.d1, v.tf);
        end
    endtask

    initial begin
        //                 name            r  c0 s0 w0 c1 s1 w1 ak dr             g      sc ss sw a0 a1 d0             d1             tf
        tbl.push_back(mk("reset",          1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m0_req_idle",    0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m0_granted",     0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         2'b01, 1, 1, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m0_wait",        0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         2'b01, 1, 1, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m0_ack",         0, 1, 1, 1, 0, 0, 0, 1, 32'hCAFE_0001, 2'b01, 1, 1, 1, 1, 0, 32'hCAFE_0001, 32'h0,         0));
        tbl.push_back(mk("m0_release",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("idle_after_m0",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("reset2",         1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("contend_idle",   0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("contend_m0_win", 0, 1, 1, 0, 1, 1, 0, 1, 32'h1111_0000, 2'b01, 1, 1, 0, 1, 0, 32'h1111_0000, 32'h0,         0));
        tbl.push_back(mk("m0_drop_m1_pnd", 0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         2'b01, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("dead_cycle",     0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m1_granted",     0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         2'b10, 1, 1, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m1_ack_drop",    0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 2'b10, 0, 0, 0, 0, 1, 32'h0,         32'h1234_5678, 0));
        tbl.push_back(mk("idle_after_m1",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr1_req",        0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr1_own0",       0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b01, 1, 1, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr1_drop0",      0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         2'b01, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr2_req",        0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr2_own1",       0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b10, 1, 1, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr2_drop1",      0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr3_req",        0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr3_own0",       0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         2'b01, 1, 1, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr3_drop",       0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b01, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rr_idle",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m1_wr_req",      0, 0, 0, 0, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m1_wr_own",      0, 0, 0, 0, 1, 1, 1, 0, 32'h0,         2'b10, 1, 1, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("rst_during_own", 1, 0, 0, 0, 1, 1, 1, 0, 32'h0,         2'b10, 1, 1, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("after_rst",      0, 0, 0, 0, 1, 1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("regrant_m1",     0, 0, 0, 0, 1, 1, 1, 0, 32'h0,         2'b10, 1, 1, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("m1_drop",        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b10, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk("final_idle",     0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0));

        foreach (tbl[i]) apply(tbl[i]);

        // Slave never acks: stb driven in cycle 0, owner granted from cycle 1.
        apply(mk("hang_rst",  1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        apply(mk("hang_req",  0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
`ifdef WB_ARB_TIMEOUT_EN
        for (int n = 1; n <= 10; n++) begin
            apply(mk($sformatf("wdog_cyc%0d", n), 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 2'b01,
                     (n != TO), (n != TO), 0, (n == TO), 0,
                     (n == TO) ? ERR : 32'h0, 32'h0, (n > TO)));
        end
        apply(mk("wdog_drop",    0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        apply(mk("wdog_flag_hld",0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        apply(mk("wdog_rst_in",  1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        apply(mk("wdog_rst_clr", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
`else
        for (int n = 1; n <= 20; n++) begin
            apply(mk($sformatf("hang_hold%0d", n), 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 2'b01,
                     1, 1, 0, 0, 0, 32'h0, 32'h0, 0));
        end
        apply(mk("hang_drop", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b01, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        apply(mk("hang_idle", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
